// File: rtl/rtc_ctrl.sv
// SPI command front-end for an RTC: set the time, read back a coherent time
// snapshot, and arm a single sticky alarm that compares against the live time.
module rtc_ctrl #(
   parameter int unsigned HOUR_LIMIT   = 24,
   parameter int unsigned MINSEC_LIMIT = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] hours,
   input  logic [7:0] minutes,
   input  logic [7:0] seconds,
   output logic       set_load,
   output logic [7:0] set_hours,
   output logic [7:0] set_minutes,
   output logic [7:0] set_seconds,
   output logic       alarm_irq,
   output logic       cmd_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GET_H  = 3'd1,
      GET_M  = 3'd2,
      GET_S  = 3'd3,
      COMMIT = 3'd4,
      SEND_H = 3'd5,
      SEND_M = 3'd6,
      SEND_S = 3'd7
   } state_t;

   localparam logic [7:0] CMD_WRITE_TIME  = 8'h01;
   localparam logic [7:0] CMD_READ_TIME   = 8'h02;
   localparam logic [7:0] CMD_WRITE_ALARM = 8'h03;
   localparam logic [7:0] CMD_CLEAR_ALARM = 8'h04;

   // Time triplets are packed {hours, minutes, seconds}: index 2 is hours.
   logic [2:0][7:0] live;
   logic [2:0][7:0] cap_q, cap_d;
   logic [2:0][7:0] snap_q, snap_d;
   logic [2:0][7:0] set_q, set_d;
   logic [2:0][7:0] alarm_q, alarm_d;

   state_t     state_q, state_d;
   logic       tgt_alarm_q, tgt_alarm_d;
   logic       alarm_en_q, alarm_en_d;
   logic       match_q;
   logic       irq_q, irq_d;
   logic       set_load_q, set_load_d;
   logic       cmd_err_q, cmd_err_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       busy_q, busy_d;

   logic [2:0] field_ok;
   logic [2:0] field_eq;
   logic       match;
   logic       irq_clear;

   assign live = {hours, minutes, seconds};

   for (genvar gi = 0; gi < 3; gi++) begin : g_field
      localparam int unsigned LIMIT = (gi == 2) ? HOUR_LIMIT : MINSEC_LIMIT;
      assign field_ok[gi] = 32'(cap_q[gi]) < LIMIT;
      assign field_eq[gi] = live[gi] == alarm_q[gi];
   end

   assign match = alarm_en_q & (&field_eq);

   always_comb begin
      state_d     = state_q;
      tgt_alarm_d = tgt_alarm_q;
      cap_d       = cap_q;
      snap_d      = snap_q;
      set_d       = set_q;
      alarm_d     = alarm_q;
      alarm_en_d  = alarm_en_q;
      set_load_d  = 1'b0;
      cmd_err_d   = 1'b0;
      irq_clear   = 1'b0;

      if (cs_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_WRITE_TIME: begin
                        tgt_alarm_d = 1'b0;
                        state_d     = GET_H;
                     end
                     CMD_WRITE_ALARM: begin
                        tgt_alarm_d = 1'b1;
                        state_d     = GET_H;
                     end
                     CMD_READ_TIME: begin
                        snap_d  = live;
                        state_d = SEND_H;
                     end
                     CMD_CLEAR_ALARM: begin
                        irq_clear  = 1'b1;
                        alarm_en_d = 1'b0;
                     end
                     default: cmd_err_d = 1'b1;
                  endcase
               end
            end
            GET_H: if (rx_valid) begin
               cap_d[2] = rx_data;
               state_d  = GET_M;
            end
            GET_M: if (rx_valid) begin
               cap_d[1] = rx_data;
               state_d  = GET_S;
            end
            GET_S: if (rx_valid) begin
               cap_d[0] = rx_data;
               state_d  = COMMIT;
            end
            COMMIT: begin
               state_d = IDLE;
               if (&field_ok) begin
                  if (tgt_alarm_q) begin
                     alarm_d    = cap_q;
                     alarm_en_d = 1'b1;
                     irq_clear  = 1'b1;
                  end else begin
                     set_d      = cap_q;
                     set_load_d = 1'b1;
                  end
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            SEND_H: if (tx_ready) state_d = SEND_M;
            SEND_M: if (tx_ready) state_d = SEND_S;
            SEND_S: if (tx_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // A clear in the same cycle as a match rise leaves the flag low.
      if (irq_clear)
         irq_d = 1'b0;
      else if (match && !match_q)
         irq_d = 1'b1;
      else
         irq_d = irq_q;

      // Outputs are computed from the next state so they are registered yet
      // line up with the state they belong to.
      busy_d     = (state_d != IDLE);
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      case (state_d)
         SEND_H: begin tx_valid_d = 1'b1; tx_data_d = snap_d[2]; end
         SEND_M: begin tx_valid_d = 1'b1; tx_data_d = snap_d[1]; end
         SEND_S: begin tx_valid_d = 1'b1; tx_data_d = snap_d[0]; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         tgt_alarm_q <= 1'b0;
         cap_q       <= '0;
         snap_q      <= '0;
         set_q       <= '0;
         alarm_q     <= '0;
         alarm_en_q  <= 1'b0;
         match_q     <= 1'b0;
         irq_q       <= 1'b0;
         set_load_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tgt_alarm_q <= tgt_alarm_d;
         cap_q       <= cap_d;
         snap_q      <= snap_d;
         set_q       <= set_d;
         alarm_q     <= alarm_d;
         alarm_en_q  <= alarm_en_d;
         match_q     <= match;
         irq_q       <= irq_d;
         set_load_q  <= set_load_d;
         cmd_err_q   <= cmd_err_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         busy_q      <= busy_d;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign set_load    = set_load_q;
   assign set_hours   = set_q[2];
   assign set_minutes = set_q[1];
   assign set_seconds = set_q[0];
   assign alarm_irq   = irq_q;
   assign cmd_err     = cmd_err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_rtc_ctrl.sv
// Bench for rtc_ctrl: vector table for write-time commands, hand sequences for
// snapshot, alarm, abort and reset corners, then randomized transactions.
module tb_rtc_ctrl;

   logic       clk = 1'b0;
   logic       reset, cs_n, rx_valid, tx_ready;
   logic [7:0] rx_data, hours, minutes, seconds;
   logic [7:0] tx_data, set_hours, set_minutes, set_seconds;
   logic       tx_valid, set_load, alarm_irq, cmd_err, busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_load   = 0;
   int n_err    = 0;
   logic [7:0] tx_log [$];
   logic [23:0] exp_set;

   rtc_ctrl dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .set_load(set_load), .set_hours(set_hours), .set_minutes(set_minutes),
      .set_seconds(set_seconds), .alarm_irq(alarm_irq), .cmd_err(cmd_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse counters and the transferred-byte log, sampled mid-cycle.
   always @(negedge clk) begin
      if (set_load === 1'b1) n_load++;
      if (cmd_err === 1'b1) n_err++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_log.push_back(tx_data);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send4(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
   endtask

   task automatic set_time(logic [7:0] h, logic [7:0] m, logic [7:0] s);
      hours   = h;
      minutes = m;
      seconds = s;
   endtask

   function automatic logic [31:0] set_now();
      return 32'({set_hours, set_minutes, set_seconds});
   endfunction

   typedef struct {
      int              n;
      logic [3:0][7:0] b;
      int              load;
      int              err;
      logic [23:0]     set;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int bl, be, base;

      vecs[0]  = '{4, {8'h01, 8'h0C, 8'h22, 8'h05}, 1, 0, 24'h0C2205};
      vecs[1]  = '{4, {8'h01, 8'h18, 8'h00, 8'h00}, 0, 1, 24'h0C2205};
      vecs[2]  = '{4, {8'h01, 8'h17, 8'h3B, 8'h3B}, 1, 0, 24'h173B3B};
      vecs[3]  = '{4, {8'h01, 8'h00, 8'h3C, 8'h00}, 0, 1, 24'h173B3B};
      vecs[4]  = '{4, {8'h01, 8'h00, 8'h00, 8'h3C}, 0, 1, 24'h173B3B};
      vecs[5]  = '{4, {8'h01, 8'h00, 8'h00, 8'h00}, 1, 0, 24'h000000};
      vecs[6]  = '{4, {8'h01, 8'h17, 8'h3A, 8'h3B}, 1, 0, 24'h173A3B};
      vecs[7]  = '{4, {8'h01, 8'hFF, 8'h00, 8'h00}, 0, 1, 24'h173A3B};
      vecs[8]  = '{1, {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 24'h173A3B};
      vecs[9]  = '{1, {8'hA5, 8'h00, 8'h00, 8'h00}, 0, 1, 24'h173A3B};
      vecs[10] = '{1, {8'h04, 8'h00, 8'h00, 8'h00}, 0, 0, 24'h173A3B};
      vecs[11] = '{4, {8'h01, 8'h09, 8'h3B, 8'h00}, 1, 0, 24'h093B00};

      reset = 1'b1; cs_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      set_time(8'h01, 8'h00, 8'h00);
      tick(2);
      reset = 1'b0;

      // Reset state
      check("rst_tx_valid", 32'(tx_valid), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_set_load", 32'(set_load), 0);
      check("rst_set", set_now(), 0);
      check("rst_irq", 32'(alarm_irq), 0);
      check("rst_cmd_err", 32'(cmd_err), 0);
      check("rst_busy", 32'(busy), 0);

      // Write-time commit timing: COMMIT cycle, then a single load pulse.
      send4(8'h01, 8'h0C, 8'h22, 8'h05);
      check("wt_commit_busy", 32'(busy), 1);
      check("wt_commit_noload", 32'(set_load), 0);
      tick();
      check("wt_load_pulse", 32'(set_load), 1);
      check("wt_load_value", set_now(), 32'h0C2205);
      check("wt_idle_busy", 32'(busy), 0);
      tick();
      check("wt_load_end", 32'(set_load), 0);
      check("wt_hold_value", set_now(), 32'h0C2205);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         bl = n_load;
         be = n_err;
         for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[3 - j]);
         tick(3);
         check($sformatf("tbl%0d_load", i), 32'(n_load - bl), 32'(vecs[i].load));
         check($sformatf("tbl%0d_err", i), 32'(n_err - be), 32'(vecs[i].err));
         check($sformatf("tbl%0d_set", i), set_now(), 32'(vecs[i].set));
         check($sformatf("tbl%0d_busy", i), 32'(busy), 0);
      end
      exp_set = 24'h093B00;

      // Read snapshot survives a stall while the live time rolls over.
      set_time(8'd23, 8'd59, 8'd59);
      base = tx_log.size();
      send_byte(8'h02);
      set_time(8'd0, 8'd0, 8'd0);
      tick(5);
      check("rd_stall_valid", 32'(tx_valid), 1);
      check("rd_stall_data", 32'(tx_data), 32'h17);
      tx_ready = 1'b1;
      for (int k = 0; k < 10 && busy; k++) tick();
      tx_ready = 1'b0;
      check("rd_done_busy", 32'(busy), 0);
      check("rd_done_valid", 32'(tx_valid), 0);
      check("rd_count", 32'(tx_log.size() - base), 3);
      if (tx_log.size() >= base + 3)
         check("rd_bytes", 32'({tx_log[base], tx_log[base+1], tx_log[base+2]}), 32'h173B3B);

      // Alarm set, sticky, cleared, no re-trigger.
      set_time(8'd1, 8'd0, 8'd0);
      send4(8'h03, 8'h07, 8'h00, 8'h0A);
      tick(3);
      check("al_idle_irq", 32'(alarm_irq), 0);
      set_time(8'd7, 8'd0, 8'd10);
      tick();
      check("al_fire", 32'(alarm_irq), 1);
      tick(4);
      check("al_sticky", 32'(alarm_irq), 1);
      send_byte(8'h04);
      check("al_cleared", 32'(alarm_irq), 0);
      tick(5);
      check("al_no_retrigger", 32'(alarm_irq), 0);

      // Bad alarm write keeps old alarm; valid write clears the flag.
      set_time(8'd1, 8'd0, 8'd0);
      send4(8'h03, 8'h02, 8'h03, 8'h04);
      tick(3);
      be = n_err;
      send4(8'h03, 8'h18, 8'h00, 8'h00);
      tick(2);
      check("al_bad_err", 32'(n_err - be), 1);
      set_time(8'd2, 8'd3, 8'd4);
      tick();
      check("al_kept_regs", 32'(alarm_irq), 1);
      set_time(8'd1, 8'd0, 8'd0);
      send4(8'h03, 8'h02, 8'h03, 8'h04);
      tick(2);
      check("al_write_clears", 32'(alarm_irq), 0);
      set_time(8'd2, 8'd3, 8'd4);
      send_byte(8'h04);
      check("al_clear_wins", 32'(alarm_irq), 0);
      tick(3);
      check("al_clear_wins_hold", 32'(alarm_irq), 0);

      // cs_n abort mid-command; trailing bytes decode as commands.
      bl = n_load;
      be = n_err;
      send_byte(8'h01);
      send_byte(8'h0C);
      cs_n = 1'b1;
      rx_data = 8'h05;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      cs_n = 1'b0;
      check("ab_idle", 32'(busy), 0);
      send_byte(8'h22);
      check("ab_unknown_22", 32'(cmd_err), 1);
      send_byte(8'h05);
      tick(3);
      check("ab_no_load", 32'(n_load - bl), 0);
      check("ab_err_count", 32'(n_err - be), 2);
      check("ab_set_kept", set_now(), 32'(exp_set));

      // Reset during SEND_M.
      set_time(8'd3, 8'd4, 8'd5);
      send4(8'h03, 8'h03, 8'h04, 8'h05);
      tick(3);
      check("rs_irq_pre", 32'(alarm_irq), 1);
      send_byte(8'h02);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check("rs_in_send_m", 32'({tx_valid, tx_data}), 32'h104);
      reset = 1'b1;
      tick();
      check("rs_tx_valid", 32'(tx_valid), 0);
      check("rs_busy", 32'(busy), 0);
      check("rs_irq", 32'(alarm_irq), 0);
      check("rs_set", set_now(), 0);
      reset = 1'b0;
      exp_set = 24'h000000;
      tick();

      // Randomized transactions against a transaction-level model.
      for (int it = 0; it < 60; it++) begin
         int op;
         op = $urandom_range(0, 3);
         bl = n_load;
         be = n_err;
         case (op)
            0: begin
               logic [7:0] h, m, s;
               int ok;
               h = 8'($urandom_range(0, 27));
               m = 8'($urandom_range(0, 63));
               s = 8'($urandom_range(0, 63));
               ok = (h < 24 && m < 60 && s < 60) ? 1 : 0;
               send4(8'h01, h, m, s);
               tick(3);
               if (ok == 1) exp_set = {h, m, s};
               check("rnd_wt_load", 32'(n_load - bl), 32'(ok));
               check("rnd_wt_err", 32'(n_err - be), 32'(1 - ok));
               check("rnd_wt_set", set_now(), 32'(exp_set));
            end
            1: begin
               logic [23:0] snap;
               set_time(8'($urandom), 8'($urandom), 8'($urandom));
               snap = {hours, minutes, seconds};
               base = tx_log.size();
               send_byte(8'h02);
               for (int k = 0; k < 80 && busy; k++) begin
                  tx_ready = 1'($urandom_range(0, 1));
                  set_time(8'($urandom), 8'($urandom), 8'($urandom));
                  tick();
               end
               tx_ready = 1'b0;
               check("rnd_rd_done", 32'(busy), 0);
               check("rnd_rd_count", 32'(tx_log.size() - base), 3);
               if (tx_log.size() >= base + 3)
                  check("rnd_rd_bytes", 32'({tx_log[base], tx_log[base+1], tx_log[base+2]}), 32'(snap));
            end
            2: begin
               logic [7:0] b;
               do b = 8'($urandom); while (b >= 8'h01 && b <= 8'h04);
               send_byte(b);
               tick(2);
               check("rnd_unk_err", 32'(n_err - be), 1);
               check("rnd_unk_load", 32'(n_load - bl), 0);
            end
            default: begin
               int nb;
               send_byte($urandom_range(0, 1) == 1 ? 8'h03 : 8'h01);
               nb = $urandom_range(0, 3);
               for (int j = 0; j < nb; j++) send_byte(8'($urandom_range(0, 20)));
               cs_n = 1'b1;
               tick();
               cs_n = 1'b0;
               tick(2);
               check("rnd_ab_load", 32'(n_load - bl), 0);
               check("rnd_ab_err", 32'(n_err - be), 0);
               check("rnd_ab_busy", 32'(busy), 0);
               check("rnd_ab_set", set_now(), 32'(exp_set));
            end
         endcase
      end
      check("rnd_irq_quiet", 32'(alarm_irq), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
